// File: rtl/i2s_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_if
// Description : Parallel stereo-pair handshake between an audio source and
//               the i2s_tx serializer (valid/ready, one pair per transfer).
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_tx_if #(
  parameter int PDATA_WIDTH = 32
);
  logic [PDATA_WIDTH-1:0] pldata_in;
  logic [PDATA_WIDTH-1:0] prdata_in;
  logic                   valid_in;
  logic                   ready_out;

  // Audio source side
  modport master (
    output pldata_in,
    output prdata_in,
    output valid_in,
    input  ready_out
  );

  // Serializer side
  modport slave (
    input  pldata_in,
    input  prdata_in,
    input  valid_in,
    output ready_out
  );
endinterface
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx
// Description : I2S transmitter. Buffers one stereo pair, serializes it MSB
//               first with the standard one-bit I2S delay, zero-pads each
//               slot and emits a silent frame plus an underrun pulse when no
//               pair is waiting at a frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx #(
  parameter int PDATA_WIDTH = 32,
  parameter int SLOT_WIDTH  = 32
) (
  input  logic     sclk_in,
  input  logic     arstn_in,
  i2s_tx_if.slave  bus,
  output logic     lrck_out,
  output logic     sdata_out,
  output logic     underrun_out
);

  localparam int              c_FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int              c_CW         = $clog2(c_FRAME_BITS);
  localparam int              c_PAD        = SLOT_WIDTH - PDATA_WIDTH;
  localparam logic [c_CW-1:0] c_LAST       = c_CW'(c_FRAME_BITS - 1);
  localparam logic [c_CW-1:0] c_SLOT       = c_CW'(SLOT_WIDTH);

  // A slot narrower than the sample cannot carry it without truncation
  if (SLOT_WIDTH < PDATA_WIDTH) begin : g_slot_width_check
    $error("i2s_tx: SLOT_WIDTH must be >= PDATA_WIDTH");
  end

  logic [c_CW-1:0]         r_cnt;
  logic [c_CW-1:0]         w_cnt_next;
  logic                    w_wrap;
  logic                    w_accept;
  logic                    r_hold_full;
  logic [PDATA_WIDTH-1:0]  r_hold_l;
  logic [PDATA_WIDTH-1:0]  r_hold_r;
  logic [SLOT_WIDTH-1:0]   w_slot_l;
  logic [SLOT_WIDTH-1:0]   w_slot_r;
  logic [c_FRAME_BITS-1:0] w_frame_load;
  logic [c_FRAME_BITS-1:0] r_shift;
  logic                    r_lrck;
  logic                    r_sdata;
  logic                    r_underrun;

  assign w_wrap     = (r_cnt == c_LAST);
  assign w_cnt_next = w_wrap ? '0 : r_cnt + c_CW'(1);
  assign w_accept   = bus.valid_in && !r_hold_full;

  // Sample sits in the top of its slot; the low c_PAD bits stay zero
  assign w_slot_l     = SLOT_WIDTH'(r_hold_l) << c_PAD;
  assign w_slot_r     = SLOT_WIDTH'(r_hold_r) << c_PAD;
  assign w_frame_load = r_hold_full ? {w_slot_l, w_slot_r} : '0;

  assign bus.ready_out = !r_hold_full;
  assign lrck_out      = r_lrck;
  assign sdata_out     = r_sdata;
  assign underrun_out  = r_underrun;

  // Frame position counter and word select, lrck tracks the counter value
  always_ff @(posedge sclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_cnt  <= '0;
      r_lrck <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_lrck <= (w_cnt_next >= c_SLOT);
    end
  end

  // Frame shifter: MSB of the shifter is frame bit r_cnt, registered out one
  // cycle later, which yields the I2S one-bit delay across the wrap as well
  always_ff @(posedge sclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_shift <= '0;
      r_sdata <= 1'b0;
    end else begin
      r_sdata <= r_shift[c_FRAME_BITS-1];
      if (w_wrap) begin
        r_shift <= w_frame_load;
      end else begin
        r_shift <= {r_shift[c_FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  // One-entry holding register; a pair accepted on an empty wrap edge waits
  // for the next frame rather than bypassing into the current one
  always_ff @(posedge sclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
    end else begin
      if (w_accept) begin
        r_hold_l <= bus.pldata_in;
        r_hold_r <= bus.prdata_in;
      end
      if (w_wrap && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
      end
    end
  end

  // Underrun pulse for the cycle after a wrap edge that found no pair
  always_ff @(posedge sclk_in or negedge arstn_in) begin
    if (!arstn_in) begin
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_wrap && !r_hold_full;
    end
  end

endmodule
`default_nettype wire
